instr_fetch: RTL and testbench

Instruction fetch stage for the 16-bit CPU. Sits directly upstream of the next-state/control FSM and supplies the 16-bit `instr` word it decodes. Fetches sequential words from instruction memory over a req/ack handshake into a small prefetch FIFO, and presents one instruction at a time to the controller. The controller consumes the instruction in its load-new-instruction state; a redirect flushes the FIFO on branch/call/ret/ldpc.

---
 rtl/instr_fetch.sv | 140 ++++++++++++++
 tb/tb_instr_fetch.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch.sv
// Instruction fetch: sequential prefetch into a DEPTH-entry FIFO, flushed on redirect.
// Optional IFETCH_BYPASS_EN forwards an ack word straight to the controller when the FIFO is empty.
module instr_fetch #(
  parameter int          DEPTH    = 2,
  parameter logic [15:0] RESET_PC = 16'h0000
) (
  input  logic        i_clk,
  input  logic        i_rst,
  output logic        o_mem_req,
  output logic [15:0] o_mem_addr,
  input  logic        i_mem_ack,
  input  logic [15:0] i_mem_rdata,
  output logic        o_ir_valid,
  input  logic        i_ir_ready,
  output logic [15:0] o_instr,
  output logic [15:0] o_pc,
  input  logic        i_redirect,
  input  logic [15:0] i_redirect_addr
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic [1:0] {S_FETCH, S_STALL, S_DISCARD} state_t;

  state_t        r_state;
  logic          r_mem_req;
  logic [15:0]   r_mem_addr;
  logic [15:0]   r_fetch_pc;
  logic [15:0]   r_fifo_addr [DEPTH];
  logic [15:0]   r_fifo_word [DEPTH];
  logic [AW-1:0] r_rd;
  logic [AW-1:0] r_wr;
  logic [CW-1:0] r_count;

  logic          w_empty;
  logic          w_ack;
  logic          w_ack_fetch;
  logic          w_push;
  logic          w_pop;
  logic          w_room;
  logic [CW-1:0] w_count_nxt;
  logic [15:0]   w_pc_inc;

  assign w_empty     = (r_count == '0);
  assign w_ack       = r_mem_req & i_mem_ack;
  // Only a FETCH-state ack carries a live word; DISCARD acks and redirect-cycle acks are dropped.
  assign w_ack_fetch = w_ack & (r_state == S_FETCH) & ~i_redirect;
  assign w_pop       = ~w_empty & i_ir_ready & ~i_redirect;
  assign w_count_nxt = r_count + CW'(w_push) - CW'(w_pop);
  assign w_room      = (w_count_nxt < CW'(DEPTH));
  assign w_pc_inc    = r_fetch_pc + 16'd1;

  assign o_mem_req  = r_mem_req;
  assign o_mem_addr = r_mem_addr;

`ifdef IFETCH_BYPASS_EN
  logic w_byp;
  assign w_byp      = w_empty & w_ack_fetch;
  assign w_push     = w_ack_fetch & ~(w_byp & i_ir_ready);
  assign o_ir_valid = ~w_empty | w_byp;
  assign o_instr    = !w_empty ? r_fifo_word[r_rd] : (w_byp ? i_mem_rdata : 16'h0);
  assign o_pc       = !w_empty ? r_fifo_addr[r_rd] : (w_byp ? r_fetch_pc : 16'h0);
`else
  assign w_push     = w_ack_fetch;
  assign o_ir_valid = ~w_empty;
  assign o_instr    = w_empty ? 16'h0 : r_fifo_word[r_rd];
  assign o_pc       = w_empty ? 16'h0 : r_fifo_addr[r_rd];
`endif

  always_ff @(posedge i_clk) begin
    if (w_push) begin
      r_fifo_addr[r_wr] <= r_fetch_pc;
      r_fifo_word[r_wr] <= i_mem_rdata;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state    <= S_FETCH;
      r_mem_req  <= 1'b0;
      r_mem_addr <= RESET_PC;
      r_fetch_pc <= RESET_PC;
      r_rd       <= '0;
      r_wr       <= '0;
      r_count    <= '0;
    end else if (i_redirect) begin
      r_rd       <= '0;
      r_wr       <= '0;
      r_count    <= '0;
      r_fetch_pc <= i_redirect_addr;
      // An unanswered request cannot be withdrawn: wait out its ack in DISCARD.
      if (r_mem_req && !i_mem_ack) begin
        r_state <= S_DISCARD;
      end else begin
        r_state    <= S_FETCH;
        r_mem_req  <= 1'b1;
        r_mem_addr <= i_redirect_addr;
      end
    end else begin
      if (w_push) r_wr <= r_wr + AW'(1);
      if (w_pop)  r_rd <= r_rd + AW'(1);
      r_count <= w_count_nxt;
      case (r_state)
        S_FETCH: begin
          if (w_ack) begin
            r_fetch_pc <= w_pc_inc;
            if (w_room) begin
              r_mem_req  <= 1'b1;
              r_mem_addr <= w_pc_inc;
            end else begin
              r_state   <= S_STALL;
              r_mem_req <= 1'b0;
            end
          end else if (!r_mem_req && w_room) begin
            r_mem_req  <= 1'b1;
            r_mem_addr <= r_fetch_pc;
          end
        end
        S_STALL: begin
          if (w_room) begin
            r_state    <= S_FETCH;
            r_mem_req  <= 1'b1;
            r_mem_addr <= r_fetch_pc;
          end
        end
        S_DISCARD: begin
          if (i_mem_ack) begin
            r_state    <= S_FETCH;
            r_mem_req  <= 1'b1;
            r_mem_addr <= r_fetch_pc;
          end
        end
        default: begin
          r_state   <= S_FETCH;
          r_mem_req <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_instr_fetch.sv
// Scoreboard bench for instr_fetch: expected program-order stream per redirect/reset, random memory latency.
module tb_instr_fetch;
  localparam logic [15:0] KEY = 16'hA5A5;
`ifdef IFETCH_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        mem_req, mem_ack, ir_valid, ir_ready, redirect;
  logic [15:0] mem_addr, mem_rdata, instr, pc, redirect_addr;

  int          checks = 0;
  int          errors = 0;
  logic [15:0] exp_q[$];
  logic        mem_hold;
  int          max_lat;
  int          mem_wait = 0;
  int          acks;

  instr_fetch #(.DEPTH(2), .RESET_PC(16'h0000)) dut (
    .i_clk(clk), .i_rst(rst),
    .o_mem_req(mem_req), .o_mem_addr(mem_addr),
    .i_mem_ack(mem_ack), .i_mem_rdata(mem_rdata),
    .o_ir_valid(ir_valid), .i_ir_ready(ir_ready),
    .o_instr(instr), .o_pc(pc),
    .i_redirect(redirect), .i_redirect_addr(redirect_addr)
  );

  always #5 clk = ~clk;

  // Memory: word at address A is A ^ KEY; mem_wait cycles of latency per request.
  assign mem_ack   = mem_req && !mem_hold && (mem_wait == 0);
  assign mem_rdata = mem_addr ^ KEY;
  always @(posedge clk) begin
    if (mem_ack) mem_wait <= int'($urandom_range(max_lat, 0));
    else if (mem_req && mem_wait > 0) mem_wait <= mem_wait - 1;
  end

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic fail(input string name);
    checks++;
    errors++;
    $display("FAIL %s", name);
  endtask

  // The controller must see consecutive addresses starting from the latest restart point.
  task automatic restart_seq(input logic [15:0] a);
    exp_q.delete();
    for (int i = 0; i < 1024; i++) exp_q.push_back(a + 16'(i));
  endtask

  task automatic do_redirect(input logic [15:0] a);
    redirect      = 1'b1;
    redirect_addr = a;
    restart_seq(a);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic        p_rst = 1'b1;
  logic        p_req = 1'b0;
  logic        p_ack = 1'b0;
  logic [15:0] p_addr = 16'h0;

  always @(negedge clk) begin
    if (!rst && ir_valid && ir_ready && !redirect) begin
      if (exp_q.size() == 0) fail("scoreboard_empty");
      else begin
        chk("sb_pc", pc, exp_q[0]);
        chk("sb_instr", instr, exp_q[0] ^ KEY);
        void'(exp_q.pop_front());
      end
    end
    if (!p_rst && p_req && !p_ack) begin
      chk("hold_req", 16'(mem_req), 16'd1);
      chk("hold_addr", mem_addr, p_addr);
    end
    p_rst  <= rst;
    p_req  <= mem_req;
    p_ack  <= mem_ack;
    p_addr <= mem_addr;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; ir_ready = 1'b0; redirect = 1'b0; redirect_addr = 16'h0;
    mem_hold = 1'b0; max_lat = 0;
    restart_seq(16'h0000);
    repeat (3) tick();
    chk("rst_req", 16'(mem_req), 16'd0);
    chk("rst_addr", mem_addr, 16'h0000);
    chk("rst_valid", 16'(ir_valid), 16'd0);
    chk("rst_instr", instr, 16'h0000);
    chk("rst_pc", pc, 16'h0000);

    // Zero-wait streaming from reset
    rst = 1'b0; ir_ready = 1'b1;
    chk("rel_req", 16'(mem_req), 16'd0);
    tick();
    chk("r1_req", 16'(mem_req), 16'd1);
    chk("r1_addr", mem_addr, 16'h0000);
    chk("r1_valid", 16'(ir_valid), 16'(BYP));
    tick();
    chk("r2_valid", 16'(ir_valid), 16'd1);
    chk("r2_pc", pc, BYP ? 16'h0001 : 16'h0000);
    chk("r2_instr", instr, BYP ? 16'hA5A4 : 16'hA5A5);
    for (int i = 0; i < 16; i++) begin
      tick();
      chk("stream_valid", 16'(ir_valid), 16'd1);
    end

    // Stall: no consumer, two acks fill the FIFO, one pop admits exactly one more request
    ir_ready = 1'b0;
    do_redirect(16'h0100);
    tick();
    redirect = 1'b0;
    chk("stall_valid", 16'(ir_valid), 16'(BYP));
    chk("stall_addr", mem_addr, 16'h0100);
    acks = 0;
    for (int i = 0; i < 8; i++) begin
      if (mem_ack) acks++;
      tick();
    end
    chk("stall_acks", 16'(acks), 16'd2);
    chk("stall_req", 16'(mem_req), 16'd0);
    ir_ready = 1'b1;
    tick();
    ir_ready = 1'b0;
    acks = 0;
    for (int i = 0; i < 6; i++) begin
      if (mem_ack) acks++;
      tick();
    end
    chk("pop_acks", 16'(acks), 16'd1);
    chk("pop_req", 16'(mem_req), 16'd0);

    // Redirect while a request is pending: stale word must be discarded
    mem_hold = 1'b1; ir_ready = 1'b1;
    do_redirect(16'h0003);
    tick();
    redirect = 1'b0;
    chk("pend_req", 16'(mem_req), 16'd1);
    chk("pend_addr", mem_addr, 16'h0003);
    tick();
    do_redirect(16'h0040);
    tick();
    redirect = 1'b0;
    chk("disc_req", 16'(mem_req), 16'd1);
    chk("disc_addr", mem_addr, 16'h0003);
    chk("disc_valid", 16'(ir_valid), 16'd0);
    tick();
    tick();
    mem_hold = 1'b0;
    #1;
    chk("disc_ack", 16'(mem_ack), 16'd1);
    tick();
    chk("after_disc_req", 16'(mem_req), 16'd1);
    chk("after_disc_addr", mem_addr, 16'h0040);
    for (int i = 0; i < 10 && !ir_valid; i++) tick();
    if (!ir_valid) fail("first_pc_timeout");
    else chk("first_pc", pc, 16'h0040);
    repeat (3) tick();

    // Redirect coinciding with ack and pop, landing near the wrap point
    do_redirect(16'hFFFE);
    #1;
    chk("coinc_ack", 16'(mem_ack), 16'd1);
    chk("coinc_valid", 16'(ir_valid), 16'(!BYP));
    tick();
    redirect = 1'b0;
    chk("coinc_next_valid", 16'(ir_valid), 16'(BYP));
    chk("coinc_req", 16'(mem_req), 16'd1);
    chk("coinc_addr", mem_addr, 16'hFFFE);
    tick();
    chk("wrap_addr0", mem_addr, 16'hFFFF);
    tick();
    chk("wrap_addr1", mem_addr, 16'h0000);

    // Randomized traffic
    max_lat = 3;
    for (int c = 0; c < 2000; c++) begin
      redirect = 1'b0;
      ir_ready = ($urandom_range(0, 3) != 0);
      if (($urandom_range(0, 31) == 0) || (c % 100 == 99))
        do_redirect(($urandom_range(0, 3) == 0) ? 16'hFFFC + 16'($urandom_range(0, 3))
                                                : 16'($urandom));
      tick();
    end
    redirect = 1'b0;
    max_lat = 0;
    ir_ready = 1'b1;
    repeat (10) tick();

    // Reset mid-handshake
    ir_ready = 1'b0;
    mem_hold = 1'b1;
    do_redirect(16'h0200);
    tick();
    redirect = 1'b0;
    tick();
    chk("mid_req", 16'(mem_req), 16'd1);
    rst = 1'b1;
    restart_seq(16'h0000);
    tick();
    chk("mrst_req", 16'(mem_req), 16'd0);
    chk("mrst_addr", mem_addr, 16'h0000);
    chk("mrst_valid", 16'(ir_valid), 16'd0);
    chk("mrst_instr", instr, 16'h0000);
    chk("mrst_pc", pc, 16'h0000);
    rst = 1'b0; mem_hold = 1'b0; ir_ready = 1'b1;
    tick();
    chk("mrst_r1_req", 16'(mem_req), 16'd1);
    chk("mrst_r1_addr", mem_addr, 16'h0000);
    chk("mrst_r1_valid", 16'(ir_valid), 16'(BYP));
    repeat (8) tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
